// File: rtl/manchester_pkg.sv
// Manchester line-code constants and receiver state encoding,
// shared with the serializer/framer side.
package manchester_pkg;

    localparam logic [1:0] CHIP_ONE  = 2'b10;
    localparam logic [1:0] CHIP_ZERO = 2'b01;
    localparam logic [1:0] CHIP_SOF  = 2'b11;
    localparam logic [1:0] CHIP_IDLE = 2'b00;

    localparam int CHIPS_PER_BYTE = 16;

    typedef enum logic [1:0] {
        HUNT,
        SOF1,
        DATA,
        SOF_WAIT
    } state_t;

endpackage

// File: rtl/manchester_pair_decoder.sv
// Decodes one Manchester chip pair into a data bit.
// 00 and 11 are not data symbols and raise o_code_err.
module manchester_pair_decoder
    import manchester_pkg::*;
(
    input  logic [1:0] i_pair,
    output logic       o_bit,
    output logic       o_code_err
);

    always_comb begin
        o_bit      = 1'b0;
        o_code_err = 1'b0;
        unique case (i_pair)
            CHIP_ONE:  o_bit = 1'b1;
            CHIP_ZERO: o_bit = 1'b0;
            default:   o_code_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/manchester_deserializer.sv
// Manchester receiver: SOF alignment, 16-chip byte decode, AXI4-Stream out.
// Define MANCHESTER_DESER_ERRCNT_EN to add saturating error counters.
module manchester_deserializer
    import manchester_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int IDLE_MIN_CHIPS = 4
`ifdef MANCHESTER_DESER_ERRCNT_EN
    ,
    parameter int ERR_CNT_W      = 16
`endif
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 serial_in,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 locked,
    output logic                 frame_err,
    output logic                 overrun
`ifdef MANCHESTER_DESER_ERRCNT_EN
    ,
    input  logic                 cnt_clr,
    output logic [ERR_CNT_W-1:0] code_err_cnt,
    output logic [ERR_CNT_W-1:0] overrun_cnt
`endif
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_c;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_idle_cnt, w_idle_nxt;
    logic [3:0] r_chip_cnt, w_chip_nxt;
    logic       r_prev;
    logic [7:0] r_shift, w_shift_nxt;

    logic       w_bit, w_code_err;
    logic [1:0] w_pair;
    logic [7:0] w_byte;
    logic       w_byte_done, w_ferr;

    logic [7:0] r_tdata;
    logic       r_tvalid, r_frame_err, r_overrun;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], serial_in};
        end
    end

    assign w_c    = r_sync[SYNC_STAGES-1];
    // Pair = previous chip followed by the current one; only odd chips use it.
    assign w_pair = {r_prev, w_c};
    assign w_byte = {r_shift[6:0], w_bit};

    manchester_pair_decoder u_dec (
        .i_pair     (w_pair),
        .o_bit      (w_bit),
        .o_code_err (w_code_err)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= HUNT;
            r_idle_cnt <= 4'd0;
            r_chip_cnt <= 4'd0;
            r_prev     <= 1'b0;
            r_shift    <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_idle_cnt <= w_idle_nxt;
            r_chip_cnt <= w_chip_nxt;
            r_prev     <= w_c;
            r_shift    <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idle_nxt  = r_idle_cnt;
        w_chip_nxt  = 4'd0;
        w_shift_nxt = r_shift;
        w_byte_done = 1'b0;
        w_ferr      = 1'b0;
        unique case (r_state)
            HUNT: begin
                if (!w_c) begin
                    if (r_idle_cnt != 4'd15) w_idle_nxt = r_idle_cnt + 4'd1;
                end else if (r_idle_cnt >= 4'(IDLE_MIN_CHIPS)) begin
                    w_state_nxt = SOF1;
                end else begin
                    w_idle_nxt = 4'd0;
                end
            end
            SOF1: begin
                if (w_c) begin
                    w_state_nxt = DATA;
                end else begin
                    w_state_nxt = HUNT;
                    w_idle_nxt  = 4'd1;
                end
            end
            DATA: begin
                w_chip_nxt = r_chip_cnt + 4'd1;
                if (r_chip_cnt[0]) begin
                    if (w_code_err) begin
                        w_ferr      = 1'b1;
                        w_state_nxt = HUNT;
                        w_idle_nxt  = 4'd0;
                    end else begin
                        w_shift_nxt = w_byte;
                        if (r_chip_cnt == 4'(CHIPS_PER_BYTE - 1)) begin
                            w_byte_done = 1'b1;
                            w_state_nxt = SOF_WAIT;
                        end
                    end
                end
            end
            SOF_WAIT: begin
                w_chip_nxt = r_chip_cnt + 4'd1;
                if (r_chip_cnt[0]) begin
                    w_chip_nxt = 4'd0;
                    if (w_pair == CHIP_SOF) begin
                        w_state_nxt = DATA;
                    end else if (w_pair == CHIP_IDLE) begin
                        w_state_nxt = HUNT;
                        w_idle_nxt  = 4'd2;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = HUNT;
                        w_idle_nxt  = 4'd0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_tdata     <= 8'd0;
            r_tvalid    <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_ferr;
            r_overrun   <= 1'b0;
            if (w_byte_done) begin
                if (!r_tvalid || m_axis_tready) begin
                    r_tdata  <= w_byte;
                    r_tvalid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_tvalid && m_axis_tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign locked        = (r_state == DATA) || (r_state == SOF_WAIT);
    assign frame_err     = r_frame_err;
    assign overrun       = r_overrun;

`ifdef MANCHESTER_DESER_ERRCNT_EN
    logic [ERR_CNT_W-1:0] r_code_err_cnt, r_overrun_cnt;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_code_err_cnt <= '0;
            r_overrun_cnt  <= '0;
        end else if (cnt_clr) begin
            r_code_err_cnt <= '0;
            r_overrun_cnt  <= '0;
        end else begin
            if (r_frame_err && !(&r_code_err_cnt))
                r_code_err_cnt <= r_code_err_cnt + 1'b1;
            if (r_overrun && !(&r_overrun_cnt))
                r_overrun_cnt <= r_overrun_cnt + 1'b1;
        end
    end

    assign code_err_cnt = r_code_err_cnt;
    assign overrun_cnt  = r_overrun_cnt;
`endif

endmodule

// File: tb/tb_manchester_deserializer.sv
// Self-checking bench for manchester_deserializer: chip-stream model
// checked every cycle, plus directed literal expectations.
module tb_manchester_deserializer;

    localparam int SYNC     = 2;
    localparam int IDLE_MIN = 4;

    localparam int M_HUNT = 0;
    localparam int M_SOF1 = 1;
    localparam int M_DATA = 2;
    localparam int M_SOFW = 3;

    logic       aclk = 1'b0;
    logic       aresetn;
    logic       serial_in;
    logic       tready;
    logic [7:0] tdata;
    logic       tvalid;
    logic       locked;
    logic       frame_err;
    logic       overrun;
`ifdef MANCHESTER_DESER_ERRCNT_EN
    logic        cnt_clr;
    logic [15:0] code_err_cnt;
    logic [15:0] overrun_cnt;
`endif

    manchester_deserializer #(
        .SYNC_STAGES    (SYNC),
        .IDLE_MIN_CHIPS (IDLE_MIN)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .serial_in     (serial_in),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .locked        (locked),
        .frame_err     (frame_err),
        .overrun       (overrun)
`ifdef MANCHESTER_DESER_ERRCNT_EN
        ,
        .cnt_clr       (cnt_clr),
        .code_err_cnt  (code_err_cnt),
        .overrun_cnt   (overrun_cnt)
`endif
    );

    always #5 aclk = ~aclk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    bit chk_on = 1'b0;

    int ferr_seen, ovr_seen, locked_cycles, tv_cycles;
    logic [7:0] beats[$];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    always @(posedge aclk) cyc <= cyc + 1;

    always @(posedge aclk)
        if (aresetn && tvalid && tready) beats.push_back(tdata);

    // Reference model: works on the chip stream as seen after the synchronizer.
    bit         dq[$];
    bit         cq[$];
    int         mmode, midle;
    logic       e_tvalid, e_locked, e_ferr, e_ovr;
    logic [7:0] e_tdata;

    always @(posedge aclk or negedge aresetn) begin : model
        bit c, done, acc;
        logic [7:0] nb;
        if (!aresetn) begin
            mmode = M_HUNT;
            midle = 0;
            cq.delete();
            dq.delete();
            for (int i = 0; i < SYNC; i++) dq.push_back(1'b0);
            e_tvalid = 1'b0;
            e_tdata  = 8'd0;
            e_locked = 1'b0;
            e_ferr   = 1'b0;
            e_ovr    = 1'b0;
        end else begin
            c = dq.pop_front();
            dq.push_back(serial_in);
            acc    = e_tvalid && tready;
            done   = 1'b0;
            nb     = 8'd0;
            e_ferr = 1'b0;
            e_ovr  = 1'b0;
            case (mmode)
                M_HUNT: begin
                    if (!c) begin
                        if (midle < 15) midle++;
                    end else if (midle >= IDLE_MIN) begin
                        mmode = M_SOF1;
                    end else begin
                        midle = 0;
                    end
                end
                M_SOF1: begin
                    if (c) begin
                        mmode = M_DATA;
                        cq.delete();
                    end else begin
                        mmode = M_HUNT;
                        midle = 1;
                    end
                end
                M_DATA: begin
                    cq.push_back(c);
                    if (cq.size() % 2 == 0) begin
                        if (cq[cq.size()-2] == c) begin
                            e_ferr = 1'b1;
                            mmode  = M_HUNT;
                            midle  = 0;
                        end else if (cq.size() == 16) begin
                            for (int i = 0; i < 8; i++) nb[7-i] = cq[2*i];
                            done  = 1'b1;
                            mmode = M_SOFW;
                            cq.delete();
                        end
                    end
                end
                default: begin
                    cq.push_back(c);
                    if (cq.size() == 2) begin
                        if (cq[0] && cq[1]) begin
                            mmode = M_DATA;
                        end else if (!cq[0] && !cq[1]) begin
                            mmode = M_HUNT;
                            midle = 2;
                        end else begin
                            e_ferr = 1'b1;
                            mmode  = M_HUNT;
                            midle  = 0;
                        end
                        cq.delete();
                    end
                end
            endcase
            if (done) begin
                if (!e_tvalid || acc) begin
                    e_tdata  = nb;
                    e_tvalid = 1'b1;
                end else begin
                    e_ovr = 1'b1;
                end
            end else if (acc) begin
                e_tvalid = 1'b0;
            end
            e_locked = (mmode == M_DATA) || (mmode == M_SOFW);
        end
    end

    always @(negedge aclk) begin
        if (aresetn && chk_on) begin
            check("tvalid", 32'(tvalid), 32'(e_tvalid));
            check("locked", 32'(locked), 32'(e_locked));
            check("frame_err", 32'(frame_err), 32'(e_ferr));
            check("overrun", 32'(overrun), 32'(e_ovr));
            if (e_tvalid) check("tdata", 32'(tdata), 32'(e_tdata));
            if (frame_err) ferr_seen++;
            if (overrun) ovr_seen++;
            if (locked) locked_cycles++;
            if (tvalid) tv_cycles++;
        end
    end

    task automatic clear_stats();
        @(posedge aclk);
        ferr_seen     = 0;
        ovr_seen      = 0;
        locked_cycles = 0;
        tv_cycles     = 0;
        beats.delete();
    endtask

    task automatic chip(input bit b);
        @(negedge aclk);
        serial_in = b;
    endtask

    task automatic idle(input int n);
        repeat (n) chip(1'b0);
    endtask

    task automatic sof();
        chip(1'b1);
        chip(1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int bad_pair);
        for (int i = 0; i < 8; i++) begin
            if (i == bad_pair) begin
                chip(1'b1);
                chip(1'b1);
            end else if (b[7-i]) begin
                chip(1'b1);
                chip(1'b0);
            end else begin
                chip(1'b0);
                chip(1'b1);
            end
        end
    endtask

    task automatic check_beats(input string nm, input int n,
                               input logic [31:0] packed_exp);
        logic [31:0] pk;
        pk = packed_exp;
        check({nm, " count"}, 32'(beats.size()), 32'(n));
        for (int i = 0; i < n && i < beats.size(); i++)
            check({nm, " byte"}, 32'(beats[i]), 32'(pk[8*(n-1-i) +: 8]));
    endtask

    initial begin
        int t0, lat;
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0, lat;
        aresetn   = 1'b0;
        serial_in = 1'b0;
        tready    = 1'b1;
`ifdef MANCHESTER_DESER_ERRCNT_EN
        cnt_clr   = 1'b0;
`endif
        #1;
        check("rst tvalid", 32'(tvalid), 32'd0);
        check("rst tdata", 32'(tdata), 32'd0);
        check("rst locked", 32'(locked), 32'd0);
        check("rst frame_err", 32'(frame_err), 32'd0);
        check("rst overrun", 32'(overrun), 32'd0);
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        chk_on  = 1'b1;

        // Single byte with latency measurement
        clear_stats();
        idle(8);
        sof();
        send_byte(8'hA5, -1);
        t0  = cyc;
        lat = -1;
        for (int k = 0; k < 10; k++) begin
            chip(1'b0);
            if (tvalid && lat < 0) lat = cyc - t0;
        end
        idle(4);
        check("t1 latency", 32'(lat), 32'(SYNC + 1));
        check_beats("t1 beats", 1, 32'h000000A5);
        check("t1 ferr", 32'(ferr_seen), 32'd0);
        check("t1 tvalid cycles", 32'(tv_cycles), 32'd1);
        check("t1 locked cycles", 32'(locked_cycles), 32'd18);

        // Back-to-back frames
        clear_stats();
        idle(8);
        sof();
        send_byte(8'h00, -1);
        sof();
        send_byte(8'hFF, -1);
        sof();
        send_byte(8'h3C, -1);
        idle(8);
        check_beats("t2 beats", 3, 32'h0000FF3C);
        check("t2 locked cycles", 32'(locked_cycles), 32'd54);
        check("t2 ferr", 32'(ferr_seen), 32'd0);

        // Code violation inside a byte, then recovery
        clear_stats();
        idle(8);
        sof();
        send_byte(8'h12, 4);
        idle(4);
        sof();
        send_byte(8'h34, -1);
        idle(8);
        check("t3 ferr", 32'(ferr_seen), 32'd1);
        check_beats("t3 beats", 1, 32'h00000034);

        // Overrun with a stalled consumer
        clear_stats();
        tready = 1'b0;
        idle(8);
        sof();
        send_byte(8'h11, -1);
        sof();
        send_byte(8'h22, -1);
        idle(6);
        check("t4 held tdata", 32'(tdata), 32'h11);
        check("t4 held tvalid", 32'(tvalid), 32'd1);
        check("t4 overrun", 32'(ovr_seen), 32'd1);
        chip(1'b0);
        tready = 1'b1;
        idle(6);
        check_beats("t4 beats", 1, 32'h00000011);
        check("t4 tvalid after", 32'(tvalid), 32'd0);

        // Idle-length boundary for SOF acceptance
        clear_stats();
        idle(8);
        chip(1'b1);
        idle(3);
        sof();
        send_byte(8'h5A, -1);
        idle(8);
        check("t5 short locked", 32'(locked_cycles), 32'd0);
        check_beats("t5 short beats", 0, 32'h0);
        clear_stats();
        chip(1'b1);
        idle(4);
        sof();
        send_byte(8'h69, -1);
        idle(8);
        check_beats("t5 min beats", 1, 32'h00000069);

`ifdef MANCHESTER_DESER_ERRCNT_EN
        @(negedge aclk) cnt_clr = 1'b1;
        @(negedge aclk) cnt_clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            idle(8);
            sof();
            send_byte(8'h12, 1);
        end
        idle(8);
        check("cnt code_err", 32'(code_err_cnt), 32'd3);
        check("cnt overrun", 32'(overrun_cnt), 32'd0);
        @(negedge aclk) cnt_clr = 1'b1;
        @(negedge aclk) cnt_clr = 1'b0;
        check("cnt cleared", 32'(code_err_cnt), 32'd0);
`endif

        // Asynchronous reset mid-frame with a byte held
        clear_stats();
        tready = 1'b0;
        idle(8);
        sof();
        send_byte(8'h77, -1);
        sof();
        chip(1'b0); chip(1'b1); chip(1'b1); chip(1'b0);
        chip(1'b0); chip(1'b1); chip(1'b1); chip(1'b0);
        chip(1'b1);
        check("t6 pre tvalid", 32'(tvalid), 32'd1);
        check("t6 pre locked", 32'(locked), 32'd1);
        #2;
        aresetn = 1'b0;
        #1;
        check("t6 rst tvalid", 32'(tvalid), 32'd0);
        check("t6 rst tdata", 32'(tdata), 32'd0);
        check("t6 rst locked", 32'(locked), 32'd0);
        check("t6 rst frame_err", 32'(frame_err), 32'd0);
        check("t6 rst overrun", 32'(overrun), 32'd0);
        chip(1'b0);
        chip(1'b0);
        aresetn = 1'b1;
        tready  = 1'b1;
        clear_stats();
        chip(1'b1); chip(1'b1); chip(1'b0); chip(1'b0); chip(1'b1);
        idle(8);
        check_beats("t6 beats", 0, 32'h0);
        check("t6 locked", 32'(locked_cycles), 32'd0);
        check("t6 tvalid", 32'(tvalid), 32'd0);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/manchester_deserializer.md
Name: manchester_deserializer

Overview:
- Receive-side counterpart of the Manchester serializer.
- Samples a one-chip-per-clock Manchester line, finds frame alignment on a start-of-frame (SOF) code violation, decodes 16 chips into one byte, and presents the byte on an AXI4-Stream master port.
- Sits between the line input pin/loopback and the byte-stream consumer. Both ends share aclk.

Parameters:
- SYNC_STAGES, 2, number of flops in the serial_in synchronizer (minimum 2).
- IDLE_MIN_CHIPS, 4, consecutive low chips required before an SOF is accepted from HUNT (range 2..15).
- ERR_CNT_W, 16, width of the error counters (optional feature only).

Ports:
- aclk  in  1  clock; one chip per cycle.
- aresetn  in  1  asynchronous active-low reset.
- serial_in  in  1  Manchester line; idle low.
- m_axis_tdata  out  8  decoded byte.
- m_axis_tvalid  out  1  byte valid.
- m_axis_tready  in  1  consumer ready.
- locked  out  1  high in SOF_WAIT and DATA.
- frame_err  out  1  one-cycle pulse on an invalid data chip pair.
- overrun  out  1  one-cycle pulse when a byte is dropped because the output is full.

Behaviour:
- Clock and reset:
  - Single clock aclk. Reset aresetn is asynchronous, active-low.
  - Synchronizer flops clear to 0.
- Reset values:
  - m_axis_tvalid=0, m_axis_tdata=0, locked=0, frame_err=0, overrun=0.
  - state=HUNT, idle count=0.
- Line code:
  - Bit 1 = chips 1,0. Bit 0 = chips 0,1.
  - MSB first, 16 chips per byte.
  - SOF = chip pair 1,1 (code violation). Idle = continuous 0.
- Chip source: "chip" means the synchronizer output c, sampled every cycle.
- HUNT:
  - Counts consecutive c=0, saturating at 15. c=1 clears the count unless it is the SOF case below.
  - c=1 with count>=IDLE_MIN_CHIPS goes to SOF1.
- SOF1:
  - c=1 goes to DATA with the chip counter at 0.
  - c=0 means the edge was not an SOF: go to HUNT with count=1.
- DATA:
  - Shifts 16 chips; the chip counter runs 0..15.
  - On each odd chip, the pair is evaluated:
    - 10 gives 1, 01 gives 0; the bit is shifted into the byte register.
    - 00 or 11 gives a one-cycle frame_err pulse, the partial byte is discarded, and the state goes to HUNT with count=0.
  - After chip 15 with a valid pair, the byte completes and the state goes to SOF_WAIT.
- SOF_WAIT (back-to-back frames):
  - Evaluates the next chip pair.
  - 11 goes to DATA.
  - 00 goes to HUNT with count=2.
  - 10 or 01 gives frame_err and goes to HUNT with count=0.
- Output register (one deep):
  - On byte complete, if m_axis_tvalid=0, or m_axis_tvalid=1 and m_axis_tready=1 in the same cycle: load tdata and set tvalid=1 next cycle.
  - Otherwise the new byte is dropped, a one-cycle overrun pulse is issued, and the held byte is unchanged.
  - tvalid clears after a handshake when no new byte is loaded in that cycle.
  - tdata is stable while tvalid=1 and tready=0.
- Latency: m_axis_tvalid rises SYNC_STAGES+1 cycles after the last chip of the byte is present on serial_in.
- Throughput: max one byte per 18 cycles (SOF + 16 chips).
- Reset mid-frame:
  - All state clears immediately and any held or partial byte is lost.
  - After release, HUNT requires a full IDLE_MIN_CHIPS of idle again.
- Simultaneous events: frame_err and overrun are never asserted in the same cycle; overrun is asserted only on byte complete.

Optional Feature:
- Macro MANCHESTER_DESER_ERRCNT_EN.
- When defined:
  - Adds outputs code_err_cnt[ERR_CNT_W-1:0] and overrun_cnt[ERR_CNT_W-1:0].
  - Each counts frame_err and overrun pulses respectively, saturating at all-ones.
  - Both reset to 0.
  - Adds input cnt_clr (1 bit), a synchronous clear. When cnt_clr coincides with a pulse, the clear wins.
- When not defined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Shared package manchester_pkg:
  - Chip pair constants: CHIP_ONE=2'b10, CHIP_ZERO=2'b01, CHIP_SOF=2'b11, CHIP_IDLE=2'b00.
  - CHIPS_PER_BYTE=16.
  - State enum (HUNT, SOF1, DATA, SOF_WAIT).
  - These constants are shared with the serializer/framer.
- Sub-module: manchester_pair_decoder, combinational. Input is a 2-bit pair; outputs are bit and code_err. Used in DATA and SOF_WAIT.
- Synchronizer, FSM and output register stay in the top module.

Test Plan:
- Idle 8 chips, SOF, then byte 0xA5 (chips 10 01 10 01 01 10 01 10), tready=1 → one beat, tdata=0xA5, tvalid high 1 cycle, SYNC_STAGES+1 cycles after the last chip; frame_err=0.
- Idle 8 chips, SOF, then bytes 0x00, SOF, 0xFF, SOF, 0x3C back-to-back, tready=1 → three beats 0x00, 0xFF, 0x3C; locked stays high throughout the frames.
- Idle 8 chips, SOF, then 0x12 with chip pair 4 forced to 11 → one frame_err pulse, no beat. Then idle 4 chips, SOF, 0x34 → beat 0x34.
- tready=0, send 0x11 then 0x22 back-to-back → tdata holds 0x11, one overrun pulse at completion of 0x22. Raise tready → 0x11 is accepted, and no 0x22 beat appears.
- Idle 3 chips (IDLE_MIN_CHIPS=4), then 11 and a valid byte → not locked, no beat. Repeat with 4 idle chips → beat.
- Assert aresetn low at chip 9 of byte 0x5A → all outputs return to 0 asynchronously, no beat. With MANCHESTER_DESER_ERRCNT_EN: 3 forced code errors → code_err_cnt=3; cnt_clr → 0.
